// File: rtl/muldiv_unit_pkg.sv
// Shared opcode encodings, FSM state type and helpers for the iterative
// multiply/divide unit that sits beside the ALU in EX.
package muldiv_unit_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'b000,
    MDU_MULT  = 3'b001,
    MDU_MULTU = 3'b010,
    MDU_DIV   = 3'b011,
    MDU_DIVU  = 3'b100,
    MDU_MTHI  = 3'b101,
    MDU_MTLO  = 3'b110
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_e;

  // Magnitude of a two's-complement word; 0x80000000 maps to itself,
  // which is exactly the unsigned magnitude we need.
  function automatic logic [XLEN-1:0] abs_xlen(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
// start is a one-cycle command with no ready: the hazard unit only issues
// while busy is low, and any start seen while busy is dropped.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] hi;
  logic [XLEN-1:0] lo;
  mdu_state_e      dbg_state;

  modport master (
    output start, op, A, B, flush,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, A, B, flush,
    output busy, done, hi, lo, dbg_state
  );

endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU (32 radix-2 steps plus one sign-fix cycle)
// and single-cycle MTHI/MTLO, owning the architectural HI/LO registers.
module muldiv_unit
  import muldiv_unit_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  mdu_state_e        state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [63:0]       acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic              is_div_q, is_div_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic              dz_q, dz_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic              done_q, done_d;

  logic              op_signed;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [32:0]       mul_sum;
  logic [63:0]       mul_next;
  logic [32:0]       div_shift;
  logic [32:0]       div_diff;
  logic [63:0]       div_next;
  logic [63:0]       prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign op_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
  assign a_mag     = op_signed ? abs_xlen(bus.A) : bus.A;
  assign b_mag     = op_signed ? abs_xlen(bus.B) : bus.B;

  // Multiply: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Divide: acc = {partial remainder, dividend bits / quotient bits}.
  // Bit 32 of the difference is the borrow that rejects a subtraction.
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = div_shift - {1'b0, b_q};
  assign div_next  = div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                  : {div_diff[31:0],  acc_q[30:0], 1'b1};

  assign prod_fix = neg_q     ? (~acc_q + 64'd1)       : acc_q;
  assign quo_fix  = neg_q     ? (~acc_q[31:0] + 32'd1)  : acc_q[31:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    b_d       = b_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
              state_d   = ST_CALC;
              cnt_d     = 5'd0;
              acc_d     = {32'd0, a_mag};
              b_d       = b_mag;
              a_d       = bus.A;
              is_div_d  = (bus.op == MDU_DIV) || (bus.op == MDU_DIVU);
              neg_d     = op_signed & (bus.A[31] ^ bus.B[31]);
              neg_rem_d = op_signed & bus.A[31];
              dz_d      = (bus.B == '0);
            end
            MDU_MTHI: hi_d = bus.A;
            MDU_MTLO: lo_d = bus.A;
            default:  ;
          endcase
        end
      end
      ST_CALC: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = ST_FIX;
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end else if (dz_q) begin
          hi_d = a_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything else in flight, including an IDLE start.
    if (bus.flush) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      b_q       <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: hand-computed HI/LO results, busy/done
// timing, flush and reset aborts, MTHI/MTLO, and ignored start while busy.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] exp_q[$];

  muldiv_unit_if bus_if ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue a mul/div at the next edge and follow it to completion.
  // With poke set, an MTHI is offered mid-operation and must be dropped.
  task automatic run_op(input string tag, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit poke);
    int busy_cycles = 0;
    int early_done  = 0;
    exp_q.push_back(exp_hi);
    exp_q.push_back(exp_lo);
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = op;
    bus_if.A     = a;
    bus_if.B     = b;
    @(negedge clk);
    bus_if.start = 1'b0;
    while (bus_if.busy && busy_cycles < 40) begin
      busy_cycles++;
      if (bus_if.done) early_done++;
      if (poke && busy_cycles == 4) begin
        bus_if.start = 1'b1;
        bus_if.op    = MDU_MTHI;
        bus_if.A     = 32'hDEAD_BEEF;
      end else begin
        bus_if.start = 1'b0;
      end
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    check32({tag, " busy_cycles"}, busy_cycles, 33);
    check32({tag, " early_done"}, early_done, 0);
    check32({tag, " done"}, bus_if.done, 1);
    check32({tag, " hi"}, bus_if.hi, exp_q.pop_front());
    check32({tag, " lo"}, bus_if.lo, exp_q.pop_front());
    @(negedge clk);
    check32({tag, " done_clear"}, bus_if.done, 0);
  endtask

  initial begin
    int done_seen;
    rst          = 1'b1;
    bus_if.start = 1'b0;
    bus_if.op    = MDU_NOP;
    bus_if.A     = '0;
    bus_if.B     = '0;
    bus_if.flush = 1'b0;
    repeat (3) @(negedge clk);
    check32("reset busy", bus_if.busy, 0);
    check32("reset done", bus_if.done, 0);
    check32("reset hi", bus_if.hi, 0);
    check32("reset lo", bus_if.lo, 0);
    check32("reset state", bus_if.dbg_state, ST_IDLE);
    rst = 1'b0;

    run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_negneg", MDU_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA,
           32'h0000_0000, 32'd30, 1'b0);
    run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu_poke", MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, 1'b0);
    run_op("divu_zero", MDU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("div_zero_neg", MDU_DIV, 32'hFFFF_FFF0, 32'd0,
           32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b0);
    run_op("divu_big", MDU_DIVU, 32'hFFFF_FFFF, 32'h0001_0000,
           32'h0000_FFFF, 32'h0000_FFFF, 1'b0);

    // MTLO then MTHI on consecutive edges.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = MDU_MTLO;
    bus_if.A     = 32'h0000_1234;
    @(negedge clk);
    check32("mtlo lo", bus_if.lo, 32'h0000_1234);
    check32("mtlo busy", bus_if.busy, 0);
    bus_if.op = MDU_MTHI;
    bus_if.A  = 32'h0000_ABCD;
    @(negedge clk);
    bus_if.start = 1'b0;
    check32("mthi hi", bus_if.hi, 32'h0000_ABCD);
    check32("mthi lo_kept", bus_if.lo, 32'h0000_1234);
    check32("mthi busy", bus_if.busy, 0);
    check32("mthi done", bus_if.done, 0);

    // Flush a DIV in cycle T+10.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = MDU_DIV;
    bus_if.A     = 32'd1000;
    bus_if.B     = 32'd3;
    @(negedge clk);
    bus_if.start = 1'b0;
    check32("flush busy_t1", bus_if.busy, 1);
    repeat (9) @(negedge clk);
    bus_if.flush = 1'b1;
    @(negedge clk);
    bus_if.flush = 1'b0;
    check32("flush busy", bus_if.busy, 0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus_if.done || bus_if.busy) done_seen++;
      @(negedge clk);
    end
    check32("flush no_done", done_seen, 0);
    check32("flush hi", bus_if.hi, 32'h0000_ABCD);
    check32("flush lo", bus_if.lo, 32'h0000_1234);

    // Flush beats a same-cycle start, and blocks an MTLO.
    bus_if.start = 1'b1;
    bus_if.flush = 1'b1;
    bus_if.op    = MDU_MULT;
    @(negedge clk);
    check32("flush_start busy", bus_if.busy, 0);
    bus_if.op = MDU_MTLO;
    bus_if.A  = 32'h5555_5555;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.flush = 1'b0;
    check32("flush_mtlo lo", bus_if.lo, 32'h0000_1234);

    // Reset in cycle T+20 of a MULT.
    @(negedge clk);
    bus_if.start = 1'b1;
    bus_if.op    = MDU_MULT;
    bus_if.A     = 32'd6;
    bus_if.B     = 32'd9;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (19) @(negedge clk);
    check32("rst busy_before", bus_if.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check32("rst busy", bus_if.busy, 0);
    check32("rst done", bus_if.done, 0);
    check32("rst hi", bus_if.hi, 0);
    check32("rst lo", bus_if.lo, 0);

    run_op("after_rst", MDU_MULTU, 32'd6, 32'd9, 32'd0, 32'd54, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
